conv_mac_sched: RTL and testbench

- Sequencer that drives a single shared multiply-accumulate datapath through the 2x2 valid convolution of a 4x4 8-bit input with a 180°-rotated 3x3 8-bit filter.
- Generates operand select indices, accumulator clear/enable, result write strobes and a done pulse.
- Sits between the top-level run control and the single-MAC datapath.
- Its state code feeds display_current_state.

---
 rtl/conv_mac_sched_if.sv | 22 ++
 rtl/conv_mac_sched.sv | 63 ++++++
 tb/tb_conv_mac_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_sched_if.sv
// conv_mac_sched_if: run control and MAC datapath signals of the convolution sequencer
interface conv_mac_sched_if;
  logic run;
  logic mac_ready;
  logic [3:0] a_sel;
  logic [3:0] b_sel;
  logic acc_clr;
  logic acc_en;
  logic res_wr;
  logic [1:0] res_idx;
  logic busy;
  logic done;
  logic [2:0] current_state;
  modport master (
    output run, mac_ready,
    input a_sel, b_sel, acc_clr, acc_en, res_wr, res_idx, busy, done, current_state
  );
  modport slave (
    input run, mac_ready,
    output a_sel, b_sel, acc_clr, acc_en, res_wr, res_idx, busy, done, current_state
  );
endinterface

// File: rtl/conv_mac_sched.sv
// conv_mac_sched: sequences one shared MAC through a 2x2 valid convolution of a 4x4 input with a rotated 3x3 filter
module conv_mac_sched #(
  parameter int MAC_LAT = 1
) (
  input logic clk,
  input logic reset,
  conv_mac_sched_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;
  localparam logic [1:0] W_LAST = 2'(MAC_LAT == 0 ? 0 : MAC_LAT - 1);
  state_t state, state_nx;
  logic [1:0] slot, p, q, w;
  logic [3:0] tap;
  logic in_accum, tap_go, last_tap;
  assign in_accum = state == ACCUM;
  assign tap_go = in_accum && bus.mac_ready;
  assign last_tap = p == 2'd2 && q == 2'd2;
  assign tap = {1'b0, p, 1'b0} + {2'b0, p} + {2'b0, q};
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE  ? (bus.run ? CLEAR : IDLE) :
               state == CLEAR ? ACCUM :
               state == ACCUM ? ((tap_go && last_tap) ? ((MAC_LAT > 0) ? WAIT : STORE) : ACCUM) :
               state == WAIT  ? (w == W_LAST ? STORE : WAIT) :
               state == STORE ? (slot == 2'd3 ? DONE : CLEAR) :
               IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      p <= '0;
      q <= '0;
      w <= '0;
    end else begin
      state <= state_nx;
      w <= state == WAIT ? w + 2'd1 : 2'd0;
      if (state == IDLE) slot <= '0;
      else if (state == STORE) slot <= slot + 2'd1;
      // q walks filter columns, wrapping into p; both return to 0 after the ninth tap
      if (tap_go) begin
        q <= q == 2'd2 ? 2'd0 : q + 2'd1;
        p <= q != 2'd2 ? p : (p == 2'd2 ? 2'd0 : p + 2'd1);
      end
    end
  end
  assign bus.a_sel = in_accum ? {{1'b0, slot[1]} + p, {1'b0, slot[0]} + q} : 4'd0;
  assign bus.b_sel = in_accum ? 4'd8 - tap : 4'd0;
  assign bus.acc_clr = state == CLEAR;
  assign bus.acc_en = tap_go;
  assign bus.res_wr = state == STORE;
  assign bus.res_idx = state == STORE ? slot : 2'd0;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.current_state = state;
endmodule

// File: tb/tb_conv_mac_sched.sv
// tb_conv_mac_sched: scoreboard bench with a behavioural MAC and convolution reference for three MAC latencies
module tb_conv_mac_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic mac_ready = 1'b1;
  bit rand_ready = 1'b0;
  int lat = 1;
  int cyc = 0;
  int run_cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int acc = 0;
  int hist[3] = '{0, 0, 0};
  logic [7:0] a_m[16];
  logic [7:0] b_m[9];
  int res_q[$];
  int tap_q[$];
  int a1[16] = '{3, 1, 6, 5, 7, 5, 2, 7, 7, 10, 8, 9, 1, 3, 2, 10};
  int b1[9] = '{3, 1, 4, 0, 5, 1, 0, 1, 5};
  int e1[4] = '{110, 101, 110, 121};
  int a2[16] = '{1, 2, 3, 0, 0, 1, 2, 3, 3, 0, 1, 2, 2, 3, 0, 1};
  int b2[9] = '{2, 0, 1, 0, 1, 2, 1, 0, 2};
  int e2[4] = '{11, 12, 10, 11};
  int lats[3] = '{0, 1, 3};
  conv_mac_sched_if if0 ();
  conv_mac_sched_if if1 ();
  conv_mac_sched_if if3 ();
  conv_mac_sched #(.MAC_LAT(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  conv_mac_sched #(.MAC_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  conv_mac_sched #(.MAC_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  always #5 clk = ~clk;
  assign if0.run = run && lat == 0;
  assign if1.run = run && lat == 1;
  assign if3.run = run && lat == 3;
  assign if0.mac_ready = mac_ready;
  assign if1.mac_ready = mac_ready;
  assign if3.mac_ready = mac_ready;
  logic [17:0] o0, o1, o3, obs;
  logic [3:0] a_sel, b_sel;
  logic acc_clr, acc_en, res_wr, busy, done;
  logic [1:0] res_idx;
  logic [2:0] st;
  assign o0 = {if0.a_sel, if0.b_sel, if0.acc_clr, if0.acc_en, if0.res_wr, if0.res_idx, if0.busy, if0.done, if0.current_state};
  assign o1 = {if1.a_sel, if1.b_sel, if1.acc_clr, if1.acc_en, if1.res_wr, if1.res_idx, if1.busy, if1.done, if1.current_state};
  assign o3 = {if3.a_sel, if3.b_sel, if3.acc_clr, if3.acc_en, if3.res_wr, if3.res_idx, if3.busy, if3.done, if3.current_state};
  assign obs = lat == 0 ? o0 : lat == 1 ? o1 : o3;
  assign {a_sel, b_sel, acc_clr, acc_en, res_wr, res_idx, busy, done, st} = obs;
  // datapath model: the accumulator becomes visible lat cycles after it is updated
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= acc_clr ? 0 : acc_en ? acc + int'(a_m[a_sel]) * int'(b_m[b_sel]) : acc;
    hist[0] <= acc;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
  end
  function automatic int mac_out();
    return lat == 0 ? acc : hist[lat - 1];
  endfunction
  task automatic chk(bit ok, string name, int got, int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (lat=%0d cyc=%0d)", name, got, exp, lat, cyc);
    end
  endtask
  function automatic int conv(int s);
    int sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += int'(a_m[(s / 2 + i) * 4 + s % 2 + j]) * int'(b_m[(2 - i) * 3 + 2 - j]);
    return sum;
  endfunction
  task automatic load(input int a[16], input int b[9]);
    for (int i = 0; i < 16; i++) a_m[i] = 8'(a[i]);
    for (int i = 0; i < 9; i++) b_m[i] = 8'(b[i]);
  endtask
  task automatic push_run(input int e[4]);
    for (int s = 0; s < 4; s++) begin
      res_q.push_back(s * 256 + (e[s] & 255));
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          tap_q.push_back(((s / 2 + i) * 4 + s % 2 + j) * 16 + (2 - i) * 3 + (2 - j));
    end
  endtask
  task automatic monitor();
    int e, got;
    forever begin
      @(negedge clk);
      if (acc_en) begin
        e = tap_q.size() > 0 ? tap_q.pop_front() : -1;
        got = int'({a_sel, b_sel});
        chk(got == e, "tap a_sel*16+b_sel", got, e);
      end
      if (res_wr) begin
        e = res_q.size() > 0 ? res_q.pop_front() : -1;
        got = int'(res_idx) * 256 + (mac_out() & 255);
        chk(got == e, "result slot*256+value", got, e);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) mac_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic start_run(bit hold);
    step();
    run = 1'b1;
    run_cyc = cyc;
    step();
    if (!hold) run = 1'b0;
  endtask
  task automatic wait_done(int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!done) chk(1'b0, "done_timeout", 0, 1);
    else if (exp_lat >= 0) chk(cyc - run_cyc == exp_lat, "done_latency", cyc - run_cyc, exp_lat);
  endtask
  task automatic drained();
    chk(res_q.size() == 0, "results_outstanding", res_q.size(), 0);
    chk(tap_q.size() == 0, "taps_outstanding", tap_q.size(), 0);
  endtask
  initial begin
    int e[4];
    fork
      monitor();
    join_none
    repeat (3) step();
    @(negedge clk);
    chk(obs == 0, "reset_outputs", int'(obs), 0);
    step();
    reset = 1'b0;
    lat = 1;
    load(a1, b1);
    push_run(e1);
    start_run(1'b0);
    wait_done(49);
    @(negedge clk);
    chk(done == 0 && st == 0, "done_one_cycle", int'({done, st}), 0);
    drained();
    push_run(e1);
    start_run(1'b0);
    while (cyc != run_cyc + 18) step();
    mac_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(a_sel == 4'd6 && b_sel == 4'd4 && !acc_en && st == 3'd2, "stall_hold a_sel*16+b_sel",
          int'({acc_en, a_sel, b_sel}), 16 * 6 + 4);
      step();
    end
    mac_ready = 1'b1;
    wait_done(52);
    drained();
    load(a2, b2);
    lat = 0;
    push_run(e2);
    start_run(1'b0);
    wait_done(45);
    drained();
    lat = 3;
    push_run(e2);
    start_run(1'b0);
    wait_done(57);
    drained();
    lat = 1;
    load(a1, b1);
    push_run(e1);
    start_run(1'b0);
    while (cyc != run_cyc + 28) step();
    #2;
    chk(st == 3'd2 && res_idx == 0, "pre_reset_in_accum", int'(st), 2);
    reset = 1'b1;
    #1;
    chk(obs == 0, "async_reset_outputs", int'(obs), 0);
    res_q.delete();
    tap_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(!res_wr && !busy && !done, "no_activity_in_reset", int'({res_wr, busy, done}), 0);
    end
    step();
    reset = 1'b0;
    push_run(e1);
    start_run(1'b0);
    wait_done(49);
    drained();
    push_run(e1);
    start_run(1'b0);
    while (cyc != run_cyc + 20) step();
    run = 1'b1;
    step();
    run = 1'b0;
    wait_done(49);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk(st == 0 && !busy, "busy_run_ignored", int'(st), 0);
    end
    drained();
    push_run(e1);
    push_run(e1);
    start_run(1'b1);
    wait_done(49);
    chk(st == 3'd5, "held_run_state_done", int'(st), 5);
    @(negedge clk);
    chk(st == 3'd0, "held_run_state_idle", int'(st), 0);
    run_cyc = cyc;
    @(negedge clk);
    chk(st == 3'd1, "held_run_state_clear", int'(st), 1);
    step();
    run = 1'b0;
    wait_done(49);
    drained();
    for (int r = 0; r < 6; r++) begin
      lat = lats[$urandom_range(0, 2)];
      for (int i = 0; i < 16; i++) a_m[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) b_m[i] = 8'($urandom);
      for (int s = 0; s < 4; s++) e[s] = conv(s);
      push_run(e);
      rand_ready = 1'b1;
      start_run(1'b0);
      wait_done(-1);
      rand_ready = 1'b0;
      mac_ready = 1'b1;
      drained();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
